hexrec_ctrl: RTL and testbench

HEXREC_CTRL -- requirements
Module: hexrec_ctrl

---
 rtl/hexrec_ctrl.sv | 174 +++++++++++++++++
 tb/tb_hexrec_ctrl.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/hexrec_ctrl.sv
// Intel HEX record parser: assembles bytes from decoded characters,
// checks the record checksum and issues data-byte writes.
// Ports: clk, reset (async, active-low);
//   char_valid, sc, ishex, digit[3:0] from the ASCII decoder;
//   data[7:0], addr[15:0], we, rec_done, err, eof, busy.
module hexrec_ctrl (
  input  logic        clk,
  input  logic        reset,
  input  logic        char_valid,
  input  logic        sc,
  input  logic        ishex,
  input  logic [3:0]  digit,
  output logic [7:0]  data,
  output logic [15:0] addr,
  output logic        we,
  output logic        rec_done,
  output logic        err,
  output logic        eof,
  output logic        busy
);

  typedef enum logic [2:0] {
    IDLE, LEN, ADDR, TYPE, DATA, CSUM, DONE
  } state_t;

  state_t      state_q, state_d;
  logic        phase_q, phase_d;
  logic [3:0]  hi_q, hi_d;
  logic [7:0]  cnt_q, cnt_d;
  logic [7:0]  len_q, len_d;
  logic [7:0]  type_q, type_d;
  logic [15:0] base_q, base_d;
  logic [7:0]  sum_q, sum_d;

  logic [7:0]  data_d;
  logic [15:0] addr_d;
  logic        we_d, rec_done_d, err_d;
  logic        eof_d, busy_d;

  logic [7:0]  byte_v;
  logic [7:0]  sum_n;

  assign byte_v = {hi_q, digit};
  assign sum_n  = sum_q + byte_v;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= IDLE;
      phase_q  <= 1'b0;
      hi_q     <= '0;
      cnt_q    <= '0;
      len_q    <= '0;
      type_q   <= '0;
      base_q   <= '0;
      sum_q    <= '0;
      data     <= '0;
      addr     <= '0;
      we       <= 1'b0;
      rec_done <= 1'b0;
      err      <= 1'b0;
      eof      <= 1'b0;
      busy     <= 1'b0;
    end else begin
      state_q  <= state_d;
      phase_q  <= phase_d;
      hi_q     <= hi_d;
      cnt_q    <= cnt_d;
      len_q    <= len_d;
      type_q   <= type_d;
      base_q   <= base_d;
      sum_q    <= sum_d;
      data     <= data_d;
      addr     <= addr_d;
      we       <= we_d;
      rec_done <= rec_done_d;
      err      <= err_d;
      eof      <= eof_d;
      busy     <= busy_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    phase_d    = phase_q;
    hi_d       = hi_q;
    cnt_d      = cnt_q;
    len_d      = len_q;
    type_d     = type_q;
    base_d     = base_q;
    sum_d      = sum_q;
    data_d     = data;
    addr_d     = addr;
    we_d       = 1'b0;
    rec_done_d = 1'b0;
    err_d      = 1'b0;
    eof_d      = eof;

    if (char_valid) begin
      if (state_q == IDLE) begin
        if (sc) begin
          state_d = LEN;
          sum_d   = '0;
          phase_d = 1'b0;
        end
      end else if (state_q != DONE) begin
        // A new ':' wins over a bad character
        if (sc) begin
          err_d   = 1'b1;
          state_d = LEN;
          sum_d   = '0;
          phase_d = 1'b0;
        end else if (!ishex) begin
          err_d   = 1'b1;
          state_d = IDLE;
          phase_d = 1'b0;
        end else if (!phase_q) begin
          hi_d    = digit;
          phase_d = 1'b1;
        end else begin
          phase_d = 1'b0;
          sum_d   = sum_n;
          case (state_q)
            LEN: begin
              len_d   = byte_v;
              cnt_d   = '0;
              state_d = ADDR;
            end
            ADDR: begin
              if (cnt_q == 8'd0) begin
                base_d[15:8] = byte_v;
                cnt_d        = 8'd1;
              end else begin
                base_d[7:0] = byte_v;
                state_d     = TYPE;
              end
            end
            TYPE: begin
              type_d  = byte_v;
              cnt_d   = '0;
              state_d = (len_q != 8'd0) ? DATA : CSUM;
            end
            DATA: begin
              if (type_q == 8'h00) begin
                we_d   = 1'b1;
                data_d = byte_v;
                addr_d = base_q + {8'h00, cnt_q};
              end
              cnt_d = cnt_q + 8'd1;
              if (cnt_q == len_q - 8'd1) state_d = CSUM;
            end
            CSUM: begin
              if (sum_n == 8'h00) begin
                rec_done_d = 1'b1;
                if (type_q == 8'h01) begin
                  eof_d   = 1'b1;
                  state_d = DONE;
                end else begin
                  state_d = IDLE;
                end
              end else begin
                err_d   = 1'b1;
                state_d = IDLE;
              end
            end
            default: state_d = IDLE;
          endcase
        end
      end
    end

    busy_d = (state_d != IDLE) && (state_d != DONE);
  end

endmodule

// File: tb/tb_hexrec_ctrl.sv
// Bench for hexrec_ctrl: directed records plus random records,
// checked against a byte-array record model.
module tb_hexrec_ctrl;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        char_valid = 1'b0;
  logic        sc = 1'b0;
  logic        ishex = 1'b0;
  logic [3:0]  digit = 4'h0;
  logic [7:0]  data;
  logic [15:0] addr;
  logic        we, rec_done, err, eof, busy;

  hexrec_ctrl dut (
    .clk(clk), .reset(reset), .char_valid(char_valid),
    .sc(sc), .ishex(ishex), .digit(digit),
    .data(data), .addr(addr), .we(we),
    .rec_done(rec_done), .err(err), .eof(eof), .busy(busy)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // model: 0 idle, 1 inside a record, 2 finished (EOF seen)
  int         m_mode = 0;
  logic [7:0] m_q[$];
  bit         m_half = 0;
  logic [3:0] m_hi = 0;
  bit         m_eof = 0;
  bit         e_we, e_done, e_err;
  logic [7:0]  e_data;
  logic [15:0] e_addr;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic bit is_hex(input byte c);
    return (c >= "0" && c <= "9") || (c >= "A" && c <= "F");
  endfunction

  function automatic logic [3:0] hex_val(input byte c);
    if (c >= "0" && c <= "9") return 4'(c - 8'd48);
    if (c >= "A" && c <= "F") return 4'(c - 8'd55);
    return 4'h0;
  endfunction

  task automatic model(input byte c);
    int k, len, s;
    e_we = 0; e_done = 0; e_err = 0;
    if (m_mode == 0) begin
      if (c == ":") begin
        m_mode = 1; m_q.delete(); m_half = 0;
      end
    end else if (m_mode == 1) begin
      if (c == ":") begin
        e_err = 1; m_q.delete(); m_half = 0;
      end else if (!is_hex(c)) begin
        e_err = 1; m_mode = 0;
      end else if (!m_half) begin
        m_half = 1; m_hi = hex_val(c);
      end else begin
        m_half = 0;
        m_q.push_back({m_hi, hex_val(c)});
        k = m_q.size() - 1;
        if (k >= 4) begin
          len = int'(m_q[0]);
          if (k <= 3 + len && m_q[3] == 8'h00) begin
            e_we   = 1;
            e_data = m_q[k];
            e_addr = 16'(int'({m_q[1], m_q[2]}) + k - 4);
          end
          if (k == 4 + len) begin
            s = 0;
            foreach (m_q[i]) s += int'(m_q[i]);
            if (s % 256 == 0) begin
              e_done = 1;
              if (m_q[3] == 8'h01) begin
                m_eof = 1; m_mode = 2;
              end else m_mode = 0;
            end else begin
              e_err = 1; m_mode = 0;
            end
          end
        end
      end
    end
  endtask

  task automatic send(input byte c);
    model(c);
    @(negedge clk);
    char_valid = 1'b1;
    sc    = (c == ":");
    ishex = is_hex(c);
    digit = hex_val(c);
    @(posedge clk);
    #1;
    char_valid = 1'b0; sc = 1'b0; ishex = 1'b0; digit = 4'h0;
    chk("we", 32'(we), 32'(e_we));
    chk("rec_done", 32'(rec_done), 32'(e_done));
    chk("err", 32'(err), 32'(e_err));
    chk("eof", 32'(eof), 32'(m_eof));
    chk("busy", 32'(busy), 32'(m_mode == 1));
    if (e_we) begin
      chk("data", 32'(data), 32'(e_data));
      chk("addr", 32'(addr), 32'(e_addr));
    end
    repeat ($urandom_range(0, 2)) begin
      @(posedge clk);
      #1;
      chk("idle_we", 32'(we), 32'd0);
      chk("idle_err", 32'(err | rec_done), 32'd0);
      chk("idle_busy", 32'(busy), 32'(m_mode == 1));
    end
  endtask

  task automatic send_str(input string s);
    for (int i = 0; i < s.len(); i++) send(s[i]);
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_data"}, 32'(data), 32'd0);
    chk({tag, "_addr"}, 32'(addr), 32'd0);
    chk({tag, "_flags"}, 32'({we, rec_done, err, eof, busy}), 32'd0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b0;
    #1;
    chk_zero("rst");
    m_mode = 0; m_half = 0; m_eof = 0; m_q.delete();
    repeat (2) @(negedge clk);
    chk_zero("rst_hold");
    reset = 1'b1;
  endtask

  function automatic string rand_record();
    string s;
    logic [7:0] b[$];
    int len, sum, pos;
    logic [15:0] a;
    logic [7:0] t;
    logic [7:0] types[5];
    types = '{8'h00, 8'h00, 8'h00, 8'h02, 8'h04};
    len = $urandom_range(0, 5);
    a = ($urandom_range(0, 3) == 0) ? 16'hFFFD : 16'($urandom);
    t = types[$urandom_range(0, 4)];
    b.push_back(8'(len));
    b.push_back(a[15:8]);
    b.push_back(a[7:0]);
    b.push_back(t);
    for (int i = 0; i < len; i++) b.push_back(8'($urandom));
    sum = 0;
    foreach (b[i]) sum += int'(b[i]);
    b.push_back(8'(256 - sum % 256));
    if ($urandom_range(0, 3) == 0) b[b.size() - 1] ^= 8'h01;
    s = ":";
    foreach (b[i]) s = {s, $sformatf("%02X", b[i])};
    if ($urandom_range(0, 7) == 0) begin
      pos = $urandom_range(1, s.len() - 1);
      s.putc(pos, ($urandom_range(0, 1) == 0) ? "a" : ":");
    end
    return {s, "\r\n"};
  endfunction

  initial begin
    #2;
    chk_zero("por");
    repeat (2) @(negedge clk);
    reset = 1'b1;

    send_str(":0300300002337A1E\r\n");
    send_str(":0300300002337A1F\r\n");
    send_str(":02FFFF00AABB9B\r\n");
    send_str(":03G");
    chk("g_idle", 32'(busy), 32'd0);

    for (int r = 0; r < 40; r++) send_str(rand_record());

    send_str("\r\n:0300");
    do_reset();
    send_str("\r\n:0300300002337A1E\r\n");

    send_str(":03:00000001FF");
    chk("eof_set", 32'(eof), 32'd1);
    chk("done_busy", 32'(busy), 32'd0);
    send_str("\r\n:0100000055AA\r\n:00");
    chk("eof_hold", 32'(eof), 32'd1);

    do_reset();
    send_str(":00000001FF");
    chk("eof_again", 32'(eof), 32'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout");
    $fatal(1, "timeout");
  end

endmodule
